// File: rtl/ccff_driver_pkg.sv
// Shared definitions for the ccff chain driver.
//   state_t    : driver FSM states
//   DEF_WORD_W : default bitstream word width
//   ERR_W      : width of the readback mismatch counter
package ccff_driver_pkg;

  localparam int unsigned DEF_WORD_W = 8;
  localparam int unsigned ERR_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REPLAY,
    ST_VERIFY,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer for the ccff chain driver.
// Loads one word, presents it MSB first, one bit per shift.
// Ports:
//   prog_clk, prog_reset_n : clock / async active-low reset
//   i_load  : capture i_word (only issued while empty)
//   i_word  : word to serialize
//   i_shift : consume the bit currently on o_bit
//   i_clear : discard any remaining bits (truncated final word)
//   o_bit   : current bit; holds the last shifted bit while empty
//   o_empty : no bits left to shift
module ccff_word_serializer
  import ccff_driver_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_shift,
  input  logic              i_clear,
  output logic              o_bit,
  output logic              o_empty
);

  localparam int unsigned SCW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] r_sreg;
  logic [SCW-1:0]    r_cnt;
  logic              r_last;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else begin
      if (i_shift) begin
        r_last <= r_sreg[WORD_W-1];
        r_sreg <= r_sreg << 1;
        r_cnt  <= r_cnt - SCW'(1);
      end
      if (i_clear) begin
        r_cnt <= '0;
      end
      if (i_load) begin
        r_sreg <= i_word;
        r_cnt  <= SCW'(WORD_W);
      end
    end
  end

  assign o_empty = (r_cnt == '0);
  // While empty the head line keeps the last bit that was shifted out.
  assign o_bit   = o_empty ? r_last : r_sreg[WORD_W-1];

endmodule

// File: rtl/ccff_chain_driver.sv
// Drives a configuration-flop (ccff) chain from a word-wide bitstream,
// with an optional replay/readback pass that counts mismatches seen on
// the chain tail.
// Ports:
//   prog_clk, prog_reset_n : programming clock / async active-low reset
//   start, verify          : load request (IDLE only) and readback select
//   bs_data, bs_valid      : bitstream word input, MSB shifted first
//   bs_ready               : word accepted when bs_valid && bs_ready
//   replay_req             : pulse asking upstream to restart from word 0
//   ccff_head, ccff_shift_en : serial data / shift enable to chain head
//   ccff_tail              : serial data from chain tail
//   busy, done             : not IDLE / one-cycle completion pulse
//   err_count              : saturating readback mismatch count
module ccff_chain_driver
  import ccff_driver_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 36,
  parameter int unsigned WORD_W    = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              replay_req,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned      CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] ALL_BITS = CNT_W'(CHAIN_LEN);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_bitcnt;
  logic             r_verify;
  logic [ERR_W-1:0] r_err;

  logic w_active;
  logic w_empty;
  logic w_ser_bit;
  logic w_ready;
  logic w_accept;
  logic w_shift;
  logic w_last;

  assign w_active = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
  assign w_ready  = w_active && w_empty && (r_bitcnt != ALL_BITS);
  assign w_accept = w_ready && bs_valid;
  assign w_shift  = w_active && !w_empty;
  assign w_last   = w_shift && (r_bitcnt == LAST_BIT);

  // The serializer is flushed on the final chain bit so the tail of a
  // partially used last word is dropped.
  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .i_load       (w_accept),
    .i_word       (bs_data),
    .i_shift      (w_shift),
    .i_clear      (w_last),
    .o_bit        (w_ser_bit),
    .o_empty      (w_empty)
  );

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_LOAD;
      ST_LOAD:   if (w_last) w_next = r_verify ? ST_REPLAY : ST_FINISH;
      ST_REPLAY: w_next = ST_VERIFY;
      ST_VERIFY: if (w_last) w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_bitcnt <= '0;
      r_verify <= 1'b0;
      r_err    <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_bitcnt <= '0;
        r_verify <= verify;
        r_err    <= '0;
      end else if (r_state == ST_REPLAY) begin
        r_bitcnt <= '0;
      end else if (w_shift) begin
        r_bitcnt <= r_bitcnt + CNT_W'(1);
      end
      // Tail shows the bit loaded CHAIN_LEN shifts ago, aligned with head.
      if (r_state == ST_VERIFY && w_shift && (ccff_tail != w_ser_bit) &&
          (r_err != '1)) begin
        r_err <= r_err + ERR_W'(1);
      end
    end
  end

  assign bs_ready      = w_ready;
  assign ccff_head     = w_ser_bit;
  assign ccff_shift_en = w_shift;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_FINISH);
  assign replay_req    = (r_state == ST_REPLAY);
  assign err_count     = r_err;

endmodule

// File: doc/ccff_chain_driver.md
CCFF_CHAIN_DRIVER -- requirements
Module: ccff_chain_driver

Interface
REQ-001 Parameter CHAIN_LEN, default 36, number of configuration flops in the downstream ccff chain (range 1..65535).
REQ-002 Parameter WORD_W, default 8, width of one bitstream word.
REQ-003 prog_clk  input  1  programming clock; the only clock; all state on its rising edge.
REQ-004 prog_reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 verify  input  1  sampled with start; 1 = load pass followed by readback pass.
REQ-007 bs_data  input  WORD_W  bitstream word, MSB shifted first.
REQ-008 bs_valid  input  1  bs_data valid.
REQ-009 bs_ready  output  1  driver accepts bs_data this cycle.
REQ-010 replay_req  output  1  one-cycle pulse: upstream restarts the same bitstream from word 0.
REQ-011 ccff_head  output  1  serial data into the chain head.
REQ-012 ccff_shift_en  output  1  clock enable for the chain's gated prog_clk; the chain captures ccff_head on the next rising edge when high.
REQ-013 ccff_tail  input  1  serial data from the chain tail.
REQ-014 busy  output  1  high outside IDLE.
REQ-015 done  output  1  one-cycle pulse on load/verify completion.
REQ-016 err_count  output  16  readback mismatches of the last verify run, saturating at 0xFFFF.

Function
REQ-017 States: IDLE, LOAD, REPLAY, VERIFY, FINISH.
REQ-018 IDLE -> LOAD on start; bit counter cleared, err_count cleared to 0.
REQ-019 Word transfer occurs on a cycle with bs_valid && bs_ready; bs_ready is high only in LOAD/VERIFY when the serializer is empty and bits remain.
REQ-020 Transfer latency: bit MSB of an accepted word appears on ccff_head with ccff_shift_en high in the next cycle.
REQ-021 One bit per cycle while the serializer holds bits; ccff_head is stable for the whole cycle ccff_shift_en is high.
REQ-022 Serializer empty and bs_valid low: ccff_shift_en low, ccff_head holds its last value, bit counter unchanged (stall, no lost or duplicated bits).
REQ-023 Each pass shifts exactly CHAIN_LEN bits; if CHAIN_LEN mod WORD_W != 0, only the leading MSBs of the final word are shifted and the rest discarded.
REQ-024 LOAD complete: verify=0 -> FINISH; verify=1 -> REPLAY.
REQ-025 REPLAY lasts one cycle, pulses replay_req, clears bit counter, goes to VERIFY; no shift in REPLAY.
REQ-026 VERIFY shifts the replayed stream identically to LOAD; on every shifted bit, ccff_tail != ccff_head increments err_count (saturating).
REQ-027 VERIFY complete -> FINISH; FINISH pulses done for one cycle and returns to IDLE.
REQ-028 start while busy is ignored; bs_data presented in IDLE/REPLAY/FINISH is not accepted.
REQ-029 err_count holds its value in IDLE until the next start.

Reset
REQ-030 prog_reset_n low asynchronously forces IDLE; bs_ready, ccff_head, ccff_shift_en, replay_req, busy, done = 0; err_count = 0; counters and serializer cleared.
REQ-031 Reset mid-LOAD/VERIFY abandons the run with no done pulse; ccff_shift_en drops in the same cycle reset asserts.

Structure
REQ-032 Shared package ccff_driver_pkg holds the state enumeration, default WORD_W and the err_count width constant.
REQ-033 One sub-module ccff_word_serializer (load word, shift MSB-first, empty flag); FSM, counters and comparison live in the top.

Verification
REQ-034 CHAIN_LEN=20, verify=0, words 0xA5,0x3C,0xF0 back-to-back -> ccff_head sequence 1010_0101_0011_1100_1111, exactly 20 ccff_shift_en cycles, done once, low nibble 0x0 of 0xF0 never shifted.
REQ-035 Same stream with bs_valid low 3 cycles between words -> ccff_shift_en low during gaps, identical 20-bit sequence.
REQ-036 CHAIN_LEN=20, verify=1, behavioural 20-flop chain model, upstream replays on replay_req -> 40 shifts total, err_count=0, final chain contents equal the bitstream.
REQ-037 As REQ-036 with chain flop 7 stuck at 0 -> err_count equals the count of 1-bits routed through flop 7 in the readback (nonzero), done asserted.
REQ-038 Reset asserted after 9 shifts in LOAD -> all outputs 0 immediately, no done; subsequent start performs a full clean 20-bit load.
REQ-039 start pulsed during LOAD -> ignored, single done, shift count unchanged at 20.
